pipeline_stall_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 6-stage pipeline (PC,IF,ID,EXE,MEM,MEM2,WB).

---
 rtl/pipeline_stall_ctrl_pkg.sv | 37 +++
 rtl/pipeline_stall_ctrl_perf_counter.sv | 34 +++
 rtl/pipeline_stall_ctrl.sv | 129 ++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Purpose : shared types and constants for the pipeline stall/flush sequencer.
// Latency : n/a (declarations only).
// Backpressure : n/a.
// Contents: sequencer state enum, pipeline-register index constants,
//           default divide occupancy and perf-counter width, and a helper
//           that builds a "this register and everything upstream" mask.
package pipeline_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    DIV        = 2'd1,
    REDIR_WAIT = 2'd2
  } stall_ctrl_state_t;

  // Pipeline register indices into Reg_Stall / Reg_Flush.
  localparam int REG_PC      = 0;
  localparam int REG_IFID    = 1;
  localparam int REG_IDEXE   = 2;
  localparam int REG_EXEMEM  = 3;
  localparam int REG_MEMMEM2 = 4;
  localparam int REG_MEM2WB  = 5;
  localparam int NUM_REGS    = 6;

  localparam int DIV_CYCLES_DEF = 32;
  localparam int PERF_W_DEF     = 32;

  // Holding register 'top' also has to hold every register upstream of it,
  // so stall vectors are always a contiguous run of ones from bit 0.
  function automatic logic [NUM_REGS-1:0] hold_upto(input int top);
    logic [NUM_REGS-1:0] m;
    for (int i = 0; i < NUM_REGS; i++) begin
      m[i] = (i <= top);
    end
    return m;
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_perf_counter.sv
// Purpose : free-running wrap-around event counter for stall/flush statistics.
// Latency : count visible one cycle after the incrementing cycle.
// Backpressure : none; counts every cycle 'inc' is high, wraps at 2^PERF_W.
// Ports   : clk, resetn (async active-low), inc (count enable), cnt (value).
// Only instanced by pipeline_stall_ctrl when STALL_PERF_CNT_EN is defined.
module stall_perf_counter #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inc,
  output logic [PERF_W-1:0] cnt
);

  logic [PERF_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc) begin
      cnt_d = cnt_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Purpose : central stall/flush sequencer for the PC..WB pipeline registers.
// Latency : Reg_Stall/Reg_Flush/Div_Done/Exc_Redirect combinational from state+inputs.
// Backpressure : one winning cause per cycle (exc > DCache > divide > hazard > ICache).
// Ports   : clk, resetn; hazard/busy/divide/exception inputs; per-register
//           Reg_Stall[5:0] and Reg_Flush[5:0] (0=PC .. 5=MEM2/WB), Div_Done,
//           Exc_Redirect, Perf_StallCnt/Perf_FlushCnt.
// Config  : define STALL_PERF_CNT_EN to build the perf counters; otherwise the
//           Perf_* ports read constant zero and no counter flops exist.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int PERF_W     = PERF_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ID_EX_DH_Stall,
  input  logic              ID_MEM1_DH_Stall,
  input  logic              ID_MEM2_DH_Stall,
  input  logic              ICache_Busy,
  input  logic              DCache_Busy,
  input  logic              EXE_DivStart,
  input  logic              MEM2_ExcFlush,
  output logic [5:0]        Reg_Stall,
  output logic [5:0]        Reg_Flush,
  output logic              Div_Done,
  output logic              Exc_Redirect,
  output logic [PERF_W-1:0] Perf_StallCnt,
  output logic [PERF_W-1:0] Perf_FlushCnt
);

  localparam int               CNT_W    = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

  stall_ctrl_state_t state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              exc_take;
  logic              data_hazard;

  // A second flush pulse while already waiting for the redirect is the same
  // exception seen again by the flushed pipe, so it is not accepted.
  assign exc_take    = MEM2_ExcFlush && (state_q != REDIR_WAIT);
  assign data_hazard = ID_EX_DH_Stall || ID_MEM1_DH_Stall || ID_MEM2_DH_Stall;

  always_comb begin
    Reg_Stall    = '0;
    Reg_Flush    = '0;
    Div_Done     = 1'b0;
    Exc_Redirect = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;

    if (exc_take || (state_q == REDIR_WAIT)) begin
      // Squash everything behind the PC; PC waits for the fetch miss to
      // drain before it can take the vector. Any divide in flight dies here.
      Reg_Flush = ~hold_upto(REG_PC);
      cnt_d     = '0;
      if (ICache_Busy) begin
        Reg_Stall[REG_PC] = 1'b1;
        state_d           = REDIR_WAIT;
      end else begin
        Exc_Redirect = 1'b1;
        state_d      = RUN;
      end
    end else begin
      // Result stays valid for as long as a DCache stall keeps us in DIV.
      Div_Done = (state_q == DIV) && (cnt_q == '0);
      if (DCache_Busy) begin
        // Whole pipe up to MEM2 frozen; sequencer state frozen with it.
        Reg_Stall              = hold_upto(REG_MEMMEM2);
        Reg_Flush[REG_MEM2WB]  = 1'b1;
      end else if ((state_q == RUN) && EXE_DivStart) begin
        Reg_Stall              = hold_upto(REG_IDEXE);
        Reg_Flush[REG_EXEMEM]  = 1'b1;
        state_d                = DIV;
        cnt_d                  = CNT_LOAD;
      end else if ((state_q == DIV) && (cnt_q != '0)) begin
        Reg_Stall              = hold_upto(REG_IDEXE);
        Reg_Flush[REG_EXEMEM]  = 1'b1;
        cnt_d                  = cnt_q - CNT_W'(1);
      end else begin
        // Divide finished (or idle): lower-priority causes may act now.
        if (state_q != RUN) begin
          state_d = RUN;
        end
        if (data_hazard) begin
          Reg_Stall             = hold_upto(REG_IFID);
          Reg_Flush[REG_IDEXE]  = 1'b1;
        end else if (ICache_Busy) begin
          Reg_Stall             = hold_upto(REG_PC);
          Reg_Flush[REG_IFID]   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic stall_any;
  assign stall_any = |Reg_Stall;

  stall_perf_counter #(.PERF_W(PERF_W)) u_stall_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (stall_any),
    .cnt    (Perf_StallCnt)
  );

  stall_perf_counter #(.PERF_W(PERF_W)) u_flush_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (exc_take),
    .cnt    (Perf_FlushCnt)
  );
`else
  assign Perf_StallCnt = '0;
  assign Perf_FlushCnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Purpose : self-checking bench for pipeline_stall_ctrl (directed + random).
// Latency : outputs compared 1ns after inputs change, mid low phase of clk.
// Backpressure : n/a.
module tb_pipeline_stall_ctrl;

  localparam int NDIV = 32;

  logic        clk = 1'b0;
  logic        resetn;
  logic        dh_ex, dh_m1, dh_m2, ic_busy, dc_busy, div_start, exc_flush;
  logic [5:0]  Reg_Stall, Reg_Flush;
  logic        Div_Done, Exc_Redirect;
  logic [31:0] Perf_StallCnt, Perf_FlushCnt;

  pipeline_stall_ctrl #(.DIV_CYCLES(NDIV), .PERF_W(32)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .ID_EX_DH_Stall   (dh_ex),
    .ID_MEM1_DH_Stall (dh_m1),
    .ID_MEM2_DH_Stall (dh_m2),
    .ICache_Busy      (ic_busy),
    .DCache_Busy      (dc_busy),
    .EXE_DivStart     (div_start),
    .MEM2_ExcFlush    (exc_flush),
    .Reg_Stall        (Reg_Stall),
    .Reg_Flush        (Reg_Flush),
    .Div_Done         (Div_Done),
    .Exc_Redirect     (Exc_Redirect),
    .Perf_StallCnt    (Perf_StallCnt),
    .Perf_FlushCnt    (Perf_FlushCnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: divide progress counted upward in elapsed cycles.
  bit          m_in_div;
  int          m_elapsed;
  bit          m_wait_redir;
  logic [31:0] m_stalls, m_flushes;

  // Last observed outputs, for the directed-scenario tallies.
  logic [5:0]  obs_stall, obs_flush;
  logic        obs_done, obs_redir;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_in_div     = 0;
    m_elapsed    = 0;
    m_wait_redir = 0;
    m_stalls     = '0;
    m_flushes    = '0;
  endtask

  task automatic cycle(input logic [2:0] dh, input logic ic, input logic dc,
                       input logic ds, input logic exc, input string tag);
    logic [5:0] e_stall, e_flush;
    logic       e_done, e_redir, accept;
    @(negedge clk);
    {dh_m2, dh_m1, dh_ex} = dh;
    ic_busy = ic; dc_busy = dc; div_start = ds; exc_flush = exc;
    #1;
    e_stall = '0; e_flush = '0; e_done = 0; e_redir = 0;
    accept = exc && !m_wait_redir;
    if (accept || m_wait_redir) begin
      e_flush = 6'b111110;
      if (ic) e_stall = 6'b000001;
      else    e_redir = 1;
    end else begin
      e_done = m_in_div && (m_elapsed == NDIV);
      if (dc) begin
        e_stall = 6'b011111; e_flush = 6'b100000;
      end else if ((!m_in_div && ds) || (m_in_div && m_elapsed < NDIV)) begin
        e_stall = 6'b000111; e_flush = 6'b001000;
      end else if (dh != 0) begin
        e_stall = 6'b000011; e_flush = 6'b000100;
      end else if (ic) begin
        e_stall = 6'b000001; e_flush = 6'b000010;
      end
    end
    obs_stall = Reg_Stall; obs_flush = Reg_Flush;
    obs_done = Div_Done;   obs_redir = Exc_Redirect;
    check({tag, ".stall"}, Reg_Stall, e_stall);
    check({tag, ".flush"}, Reg_Flush, e_flush);
    check({tag, ".done"},  Div_Done, e_done);
    check({tag, ".redir"}, Exc_Redirect, e_redir);
`ifdef STALL_PERF_CNT_EN
    check({tag, ".pstall"}, Perf_StallCnt, m_stalls);
    check({tag, ".pflush"}, Perf_FlushCnt, m_flushes);
`else
    check({tag, ".pstall"}, Perf_StallCnt, 0);
    check({tag, ".pflush"}, Perf_FlushCnt, 0);
`endif
    @(posedge clk);
    if (e_stall != 0) m_stalls++;
    if (accept) m_flushes++;
    if (accept || m_wait_redir) begin
      m_in_div = 0; m_elapsed = 0; m_wait_redir = ic;
    end else if (!dc) begin
      if (!m_in_div && ds) begin
        m_in_div = 1; m_elapsed = 1;
      end else if (m_in_div) begin
        if (m_elapsed < NDIV) m_elapsed++;
        else m_in_div = 0;
      end
    end
  endtask

  task automatic idle(input string tag);
    cycle(3'b000, 0, 0, 0, 0, tag);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    {dh_ex, dh_m1, dh_m2, ic_busy, dc_busy, div_start, exc_flush} = '0;
    resetn = 0;
    repeat (2) @(negedge clk);
    resetn = 1;
    model_reset();
  endtask

  initial begin
    int cnt_a, cnt_b, at;
    resetn = 0;
    {dh_ex, dh_m1, dh_m2, ic_busy, dc_busy, div_start, exc_flush} = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.stall", Reg_Stall, 6'b0);
    check("rst.flush", Reg_Flush, 6'b0);
    check("rst.done",  Div_Done, 0);
    check("rst.redir", Exc_Redirect, 0);
    check("rst.pstall", Perf_StallCnt, 0);
    check("rst.pflush", Perf_FlushCnt, 0);
    @(negedge clk);
    resetn = 1;

    // 1: single data-hazard cycle, each hazard source.
    cycle(3'b001, 0, 0, 0, 0, "t1_ex");
    check("t1_stall_const", obs_stall, 6'b000011);
    check("t1_flush_const", obs_flush, 6'b000100);
    cycle(3'b010, 1, 0, 0, 0, "t1_m1_ic");
    cycle(3'b100, 0, 0, 0, 0, "t1_m2");
    cycle(3'b000, 1, 0, 0, 0, "t1_ic");

    // 2: held divide start; 32 stall cycles, done at T+32, no restart.
    cnt_a = 0; at = -1;
    for (int k = 0; k <= NDIV; k++) begin
      cycle(3'b000, 0, 0, 1, 0, "t2_div");
      if (obs_stall[2:0] == 3'b111) cnt_a++;
      if (obs_done && at < 0) at = k;
    end
    check("t2_stall_cycles", cnt_a, NDIV);
    check("t2_done_at", at, NDIV);
    idle("t2_norestart");
    check("t2_norestart_stall", obs_stall, 6'b0);

    // 3: DCache busy while the result is ready keeps Div_Done up.
    cycle(3'b000, 0, 0, 1, 0, "t3_start");
    repeat (NDIV - 1) idle("t3_run");
    cnt_a = 0;
    for (int k = 0; k < 3; k++) begin
      cycle(3'b000, 0, 1, 0, 0, "t3_dc");
      if (obs_done) cnt_a++;
    end
    idle("t3_exit");
    if (obs_done) cnt_a++;
    check("t3_done_cycles", cnt_a, 4);
    idle("t3_back_run");
    check("t3_run_done", obs_done, 0);

    // 4: exception with ICache miss; redirect waits, repeat pulse ignored.
    cnt_a = 0; cnt_b = 0; at = -1;
    for (int k = 0; k < 6; k++) begin
      cycle(3'b000, (k < 5), 0, 0, (k == 0 || k == 2), "t4_exc");
      if (obs_flush == 6'b111110) cnt_a++;
      if (obs_redir) begin cnt_b++; at = k; end
    end
    check("t4_flush_cycles", cnt_a, 6);
    check("t4_redir_pulses", cnt_b, 1);
    check("t4_redir_at", at, 5);
    idle("t4_after");

    // 5: exception mid-divide (cnt=10) aborts it; no Div_Done later.
    cycle(3'b000, 0, 0, 1, 0, "t5_start");
    repeat (21) idle("t5_run");
    cycle(3'b000, 0, 0, 0, 1, "t5_exc");
    cnt_a = 0;
    for (int k = 0; k < 40; k++) begin
      idle("t5_after");
      if (obs_done) cnt_a++;
    end
    check("t5_no_done", cnt_a, 0);

    // 6: perf counters from a clean reset, then async reset mid-divide.
    apply_reset();
    repeat (3) cycle(3'b001, 0, 0, 0, 0, "t6_dh");
    cycle(3'b000, 0, 0, 0, 1, "t6_exc");
    idle("t6_idle");
`ifdef STALL_PERF_CNT_EN
    check("t6_pstall", Perf_StallCnt, 3);
    check("t6_pflush", Perf_FlushCnt, 1);
`else
    check("t6_pstall", Perf_StallCnt, 0);
    check("t6_pflush", Perf_FlushCnt, 0);
`endif
    cycle(3'b000, 0, 0, 1, 0, "t6_div");
    repeat (5) idle("t6_divrun");
    @(negedge clk);
    {dh_ex, dh_m1, dh_m2, ic_busy, dc_busy, div_start, exc_flush} = '0;
    #1 resetn = 0;
    #1;
    check("t6_rst.stall", Reg_Stall, 6'b0);
    check("t6_rst.flush", Reg_Flush, 6'b0);
    check("t6_rst.done",  Div_Done, 0);
    check("t6_rst.redir", Exc_Redirect, 0);
    check("t6_rst.pstall", Perf_StallCnt, 0);
    check("t6_rst.pflush", Perf_FlushCnt, 0);
    @(negedge clk);
    resetn = 1;
    model_reset();

    // Random mix against the model.
    for (int k = 0; k < 1500; k++) begin
      logic [2:0] r_dh;
      r_dh = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      cycle(r_dh, ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 30) == 0), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
